// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: test-load inputs and timing outputs
// of the master phase sequencer.
interface phase_sequencer_if;
  logic       TEST_LOAD;
  logic [7:0] TEST_S;
  logic [7:0] S;
  logic       PHI_n;
  logic       RAS_n;
  logic       READY;
  logic       CCLK;
  logic       CYC_START;
  logic       SEQ_ERR;

  modport master (
    output TEST_LOAD, TEST_S,
    input  S, PHI_n, RAS_n, READY,
    input  CCLK, CYC_START, SEQ_ERR
  );

  modport slave (
    input  TEST_LOAD, TEST_S,
    output S, PHI_n, RAS_n, READY,
    output CCLK, CYC_START, SEQ_ERR
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: 16-state Johnson sequencer dividing the
// master clock into the 1 us memory/video cycle.
module phase_sequencer (
  input  logic              CLK_n,
  input  logic              RESET,
  phase_sequencer_if.slave  bus
);

  logic [7:0] s_q, s_d;
  logic       err_q, err_d;
  logic       phi_n_q, phi_n_d;
  logic       ras_n_q, ras_n_d;
  logic       cclk_q, cclk_d;
  logic       ready_q, ready_d;
  logic       cyc_q, cyc_d;
  logic [4:0] cur_dec;
  logic [4:0] nxt_dec;
  logic [3:0] n_d;

  // Returns {legal, index} for a sequence code.
  function automatic logic [4:0] decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    case (c)
      8'h00: r = {1'b1, 4'd0};
      8'h01: r = {1'b1, 4'd1};
      8'h03: r = {1'b1, 4'd2};
      8'h07: r = {1'b1, 4'd3};
      8'h0F: r = {1'b1, 4'd4};
      8'h1F: r = {1'b1, 4'd5};
      8'h3F: r = {1'b1, 4'd6};
      8'h7F: r = {1'b1, 4'd7};
      8'hFF: r = {1'b1, 4'd8};
      8'hFE: r = {1'b1, 4'd9};
      8'hFC: r = {1'b1, 4'd10};
      8'hF8: r = {1'b1, 4'd11};
      8'hF0: r = {1'b1, 4'd12};
      8'hE0: r = {1'b1, 4'd13};
      8'hC0: r = {1'b1, 4'd14};
      8'h80: r = {1'b1, 4'd15};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Next code and outputs decoded from that next code,
  // so registered outputs always match the visible S.
  always_comb begin
    s_d     = {s_q[6:0], ~s_q[7]};
    err_d   = err_q;
    cur_dec = decode(s_q);
    if (bus.TEST_LOAD) begin
      s_d = bus.TEST_S;
    end else if (!cur_dec[4]) begin
      s_d   = 8'h00;
      err_d = 1'b1;
    end
    nxt_dec = decode(s_d);
    n_d     = nxt_dec[3:0];
    phi_n_d = 1'b1;
    ras_n_d = 1'b1;
    cclk_d  = 1'b0;
    ready_d = 1'b0;
    cyc_d   = 1'b0;
    if (nxt_dec[4]) begin
      phi_n_d = ~n_d[1];
      ras_n_d = ~(n_d[1] ^ n_d[0]);
      cclk_d  = n_d[3];
      ready_d = (n_d[3:2] == 2'b01);
      cyc_d   = (n_d == 4'd0);
    end
  end

  // Sequence, sticky error and output registers.
  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      s_q     <= 8'h00;
      err_q   <= 1'b0;
      phi_n_q <= 1'b1;
      ras_n_q <= 1'b1;
      cclk_q  <= 1'b0;
      ready_q <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      err_q   <= err_d;
      phi_n_q <= phi_n_d;
      ras_n_q <= ras_n_d;
      cclk_q  <= cclk_d;
      ready_q <= ready_d;
      cyc_q   <= cyc_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.SEQ_ERR   = err_q;
  assign bus.PHI_n     = phi_n_q;
  assign bus.RAS_n     = ras_n_q;
  assign bus.CCLK      = cclk_q;
  assign bus.READY     = ready_q;
  assign bus.CYC_START = cyc_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed checks of the Johnson
// sequence, decoded phases, test load and recovery.
`timescale 1ns/1ps
module tb_phase_sequencer;

  logic CLK_n = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_exp    = 0;
  int   pulses   = 0;

  logic [7:0] codes [16] = '{
    8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
    8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
  };

  phase_sequencer_if bus ();

  phase_sequencer dut (
    .CLK_n (CLK_n),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #31.25 CLK_n = ~CLK_n;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_n);
    #1;
  endtask

  // {PHI_n, RAS_n, CCLK, READY, CYC_START}
  function automatic logic [4:0] outs_for(input int n);
    logic phi, ras, cc, rdy, cyc;
    phi = (n % 4) < 2;
    ras = !((n % 4) == 1 || (n % 4) == 2);
    cc  = n >= 8;
    rdy = (n >= 4) && (n <= 7);
    cyc = n == 0;
    return {phi, ras, cc, rdy, cyc};
  endfunction

  function automatic logic [4:0] outs_obs();
    return {bus.PHI_n, bus.RAS_n, bus.CCLK,
            bus.READY, bus.CYC_START};
  endfunction

  initial begin
    bus.TEST_LOAD = 1'b0;
    bus.TEST_S    = 8'h00;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_S", bus.S, 8'h00);
      check("rst_outs", outs_obs(), 5'b11000);
      check("rst_err", bus.SEQ_ERR, 1'b0);
    end

    RESET = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_exp = k % 16;
      check($sformatf("walk_S%0d", k), bus.S, codes[n_exp]);
      check($sformatf("walk_o%0d", k), outs_obs(),
            outs_for(n_exp));
    end

    for (int k = 1; k <= 64; k++) begin
      tick();
      n_exp = k % 16;
      if (bus.CYC_START) pulses++;
      check("run_S", bus.S, codes[n_exp]);
      check("run_outs", outs_obs(), outs_for(n_exp));
    end
    check("run_pulses", pulses, 4);

    bus.TEST_LOAD = 1'b1;
    bus.TEST_S    = 8'hF0;
    tick();
    bus.TEST_LOAD = 1'b0;
    check("ldF0_S", bus.S, 8'hF0);
    check("ldF0_outs", outs_obs(), outs_for(12));
    for (int k = 13; k <= 16; k++) begin
      tick();
      check("ldF0_walk", bus.S, codes[k % 16]);
      check("ldF0_o", outs_obs(), outs_for(k % 16));
    end
    check("ldF0_err", bus.SEQ_ERR, 1'b0);

    bus.TEST_LOAD = 1'b1;
    bus.TEST_S    = 8'h5A;
    tick();
    bus.TEST_LOAD = 1'b0;
    check("ld5A_S", bus.S, 8'h5A);
    check("ld5A_outs", outs_obs(), 5'b11000);
    check("ld5A_err0", bus.SEQ_ERR, 1'b0);
    tick();
    check("rec_S", bus.S, 8'h00);
    check("rec_outs", outs_obs(), outs_for(0));
    check("rec_err", bus.SEQ_ERR, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("rec_walk", bus.S, codes[k]);
      check("rec_sticky", bus.SEQ_ERR, 1'b1);
    end

    bus.TEST_LOAD = 1'b1;
    bus.TEST_S    = 8'h5A;
    tick();
    check("hold_S1", bus.S, 8'h5A);
    bus.TEST_S = 8'hA5;
    tick();
    check("hold_S2", bus.S, 8'hA5);
    check("hold_outs", outs_obs(), 5'b11000);
    bus.TEST_S = 8'h07;
    tick();
    bus.TEST_LOAD = 1'b0;
    check("hold_S3", bus.S, 8'h07);
    check("hold_o3", outs_obs(), outs_for(3));
    tick();
    check("hold_adv", bus.S, 8'h0F);
    check("hold_err", bus.SEQ_ERR, 1'b1);

    RESET         = 1'b1;
    bus.TEST_LOAD = 1'b1;
    bus.TEST_S    = 8'h3F;
    tick();
    check("rl_S", bus.S, 8'h00);
    check("rl_err", bus.SEQ_ERR, 1'b0);
    check("rl_outs", outs_obs(), 5'b11000);

    RESET         = 1'b0;
    bus.TEST_S    = 8'h5A;
    tick();
    check("ir_S", bus.S, 8'h5A);
    bus.TEST_LOAD = 1'b0;
    RESET         = 1'b1;
    tick();
    check("ir_S0", bus.S, 8'h00);
    check("ir_err", bus.SEQ_ERR, 1'b0);
    RESET = 1'b0;
    tick();
    check("ir_first", bus.S, 8'h01);
    check("ir_ras", bus.RAS_n, 1'b0);
    check("ir_err2", bus.SEQ_ERR, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
